// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   Performs a W = 4*NIBBLES bit addition by time-multiplexing an external
//   combinational 4-bit adder. One nibble is processed per clock, starting with
//   the least significant nibble. The carry ripples between nibbles through a
//   register.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    operand handshake; in_a, in_b, in_cin are the operands
//   add_a/add_b/add_cin  nibble operands and carry driven into the 4-bit adder
//   add_sum/add_cout     adder results, captured on every RUN edge
//   res_valid/res_ready  result handshake; res_sum, res_cout, res_ovf are held
//                        stable while res_valid is high
//   busy                 high while an operation is in flight or awaiting drain
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic                 in_cin,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*NIBBLES-1:0] res_sum,
  output logic                 res_cout,
  output logic                 res_ovf,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] idx;
  logic [IW+1:0] base;
  logic          carry_reg;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic          last;

  // Bit offset of the current nibble.
  assign base = {idx, 2'b00};
  assign last = (idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        add_a   = a_sh[base +: 4];
        add_b   = b_sh[base +: 4];
        add_cin = carry_reg;
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Operand shadows, carry ripple and result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      carry_reg <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Shadows load only on accept so idle-time X on the operand
          // buses never reaches the adder or the result.
          if (in_valid) begin
            a_sh      <= in_a;
            b_sh      <= in_b;
            carry_reg <= in_cin;
            idx       <= '0;
            res_sum   <= '0;
          end
        end
        RUN: begin
          res_sum[base +: 4] <= add_sum;
          carry_reg          <= add_cout;
          idx                <= idx + IW'(1);
          if (last) begin
            res_cout <= add_cout;
            // Carry into the MSB is recovered from the MSB sum bit.
            res_ovf  <= add_cout ^ (add_sum[3] ^ add_a[3] ^ add_b[3]);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
module tb_nibble_serial_add_ctrl;

  localparam int N  = 4;
  localparam int W  = 4 * N;
  localparam int N2 = 2;
  localparam int W2 = 4 * N2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance (NIBBLES=4)
  logic         in_valid, in_ready, in_cin;
  logic [W-1:0] in_a, in_b, res_sum;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         res_valid, res_ready, res_cout, res_ovf, busy;

  nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_ovf(res_ovf),
    .busy(busy)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  // Narrow instance (NIBBLES=2)
  logic          s_in_valid, s_in_ready, s_in_cin;
  logic [W2-1:0] s_in_a, s_in_b, s_res_sum;
  logic [3:0]    s_add_a, s_add_b, s_add_sum;
  logic          s_add_cin, s_add_cout;
  logic          s_res_valid, s_res_ready, s_res_cout, s_res_ovf, s_busy;

  nibble_serial_add_ctrl #(.NIBBLES(N2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_cin(s_in_cin),
    .add_a(s_add_a), .add_b(s_add_b), .add_cin(s_add_cin),
    .add_sum(s_add_sum), .add_cout(s_add_cout),
    .res_valid(s_res_valid), .res_ready(s_res_ready),
    .res_sum(s_res_sum), .res_cout(s_res_cout), .res_ovf(s_res_ovf),
    .busy(s_busy)
  );

  assign {s_add_cout, s_add_sum} = {1'b0, s_add_a} + {1'b0, s_add_b} + {4'b0, s_add_cin};

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint unsigned full_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic c);
    return longint'(a) + longint'(b) + longint'(c);
  endfunction

  function automatic longint unsigned low_mask(input int k);
    return (64'd1 << (4 * k)) - 64'd1;
  endfunction

  // Behavioural model: what the outputs must be, derived from plain arithmetic.
  logic         m_busy, m_done, m_c, m_cout, m_ovf;
  int           m_k;
  logic [W-1:0] m_a, m_b, m_sum;

  always @(posedge clk or negedge rst_n) begin
    longint unsigned f;
    logic [W-1:0]    s;
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_k <= 0;
      m_a <= '0; m_b <= '0; m_c <= 1'b0;
      m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1; m_k <= 0;
        m_a <= in_a; m_b <= in_b; m_c <= in_cin;
        m_sum <= '0;
      end
    end else if (!m_done) begin
      f = full_sum(m_a, m_b, m_c);
      s = W'(f);
      m_k   <= m_k + 1;
      m_sum <= W'(f & low_mask(m_k + 1));
      if (m_k + 1 == N) begin
        m_done <= 1'b1;
        m_cout <= f[W];
        m_ovf  <= (m_a[W-1] == m_b[W-1]) && (s[W-1] != m_a[W-1]);
      end
    end else if (res_ready) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("in_ready", in_ready, !m_busy);
      chk("res_valid", res_valid, m_done);
      chk("busy", busy, m_busy);
      chk("res_sum", res_sum, m_sum);
      chk("res_cout", res_cout, m_cout);
      chk("res_ovf", res_ovf, m_ovf);
      if (m_busy && !m_done) begin
        chk("add_a", add_a, (m_a >> (4 * m_k)) & 4'hF);
        chk("add_b", add_b, (m_b >> (4 * m_k)) & 4'hF);
        chk("add_cin", add_cin,
            full_sum(W'(m_a & low_mask(m_k)), W'(m_b & low_mask(m_k)), m_c) >> (4 * m_k));
      end else begin
        chk("add_a_idle", add_a, 0);
        chk("add_b_idle", add_b, 0);
        chk("add_cin_idle", add_cin, 0);
      end
    end
  end

  logic [3:0] seq_a[$];
  logic       seq_cin[$];

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] xs, input logic xc, input logic xo,
                        input logic drain);
    int lat;
    chk("pre_in_ready", in_ready, 1);
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 'x; in_b = 'x; in_cin = 1'b0;
    lat = 0;
    seq_a.delete();
    seq_cin.delete();
    while (!res_valid && lat < 3 * N) begin
      seq_a.push_back(add_a);
      seq_cin.push_back(add_cin);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, N);
    chk("lit_sum", res_sum, xs);
    chk("lit_cout", res_cout, xc);
    chk("lit_ovf", res_ovf, xo);
    if (drain) begin
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk("drain_valid", res_valid, 0);
      chk("drain_in_ready", in_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_a[4];
    logic       exp_cin[4];
    int         lat;

    in_valid = 0; in_a = '0; in_b = '0; in_cin = 0; res_ready = 0;
    s_in_valid = 0; s_in_a = '0; s_in_b = '0; s_in_cin = 0; s_res_ready = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_sum", res_sum, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_cin", add_cin, 0);
    rst_n = 1;
    chk_en = 1;
    @(posedge clk); #1;

    // 0x1234 + 0x4321
    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
    exp_a = '{4'h4, 4'h3, 4'h2, 4'h1};
    for (int i = 0; i < 4; i++) chk("seq_add_a", seq_a[i], exp_a[i]);

    // Full ripple
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    exp_cin = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) chk("seq_add_cin", seq_cin[i], exp_cin[i]);

    run_op(16'h000F, 16'h0001, 1'b1, 16'h0011, 1'b0, 1'b0, 1'b1);
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);

    // Backpressure
    run_op(16'h2222, 16'h1111, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid = 1'b1; in_a = 16'hAAAA; in_b = 16'h5555;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_valid", res_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_sum", res_sum, 16'h3333);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("bp_drain_ready", in_ready, 1);
    run_op(16'h0102, 16'h0304, 1'b0, 16'h0406, 1'b0, 1'b0, 1'b1);

    // Reset during the second RUN cycle
    in_a = 16'h5A5A; in_b = 16'h1111; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_res_valid", res_valid, 0);
    chk("arst_res_sum", res_sum, 0);
    chk("arst_res_cout", res_cout, 0);
    chk("arst_res_ovf", res_ovf, 0);
    chk("arst_add_a", add_a, 0);
    chk("arst_add_b", add_b, 0);
    chk("arst_add_cin", add_cin, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h0A0A, 16'h0505, 1'b0, 16'h0F0F, 1'b0, 1'b0, 1'b1);

    // NIBBLES=2 instance
    chk("n2_in_ready", s_in_ready, 1);
    s_in_a = 8'hFF; s_in_b = 8'h01; s_in_cin = 1'b1; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    lat = 0;
    while (!s_res_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("n2_latency", lat, 2);
    chk("n2_sum", s_res_sum, 8'h01);
    chk("n2_cout", s_res_cout, 1);
    chk("n2_ovf", s_res_ovf, 0);
    s_res_ready = 1'b1;
    @(posedge clk); #1;
    s_res_ready = 1'b0;
    chk("n2_drain", s_res_valid, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
